// File: rtl/cordic_seq_engine_if.sv
// Job handshake bundle for cordic_seq_engine: request operands/config in,
// results/status out. master = job source/sink, slave = engine.
interface cordic_seq_engine_if #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_x;
  logic [WIDTH-1:0]  in_y;
  logic [WIDTH-1:0]  in_z;
  logic [1:0]        in_sys;
  logic              in_mode;
  logic [ITER_W-1:0] in_iters;
  logic              in_ovf_stop;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_x;
  logic [WIDTH-1:0]  out_y;
  logic [WIDTH-1:0]  out_z;
  logic [ITER_W-1:0] out_iters;
  logic [4:0]        out_status;

  modport master (
    output in_valid, in_x, in_y, in_z, in_sys, in_mode,
    output in_iters, in_ovf_stop, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z,
    input  out_iters, out_status
  );

  modport slave (
    input  in_valid, in_x, in_y, in_z, in_sys, in_mode,
    input  in_iters, in_ovf_stop, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z,
    output out_iters, out_status
  );
endinterface

// File: rtl/cordic_seq_engine.sv
// Sequential CORDIC engine (circular/hyperbolic/linear), one micro-rotation
// per cycle. Ports: clk, rst (async active-low), job (cordic_seq_engine_if
// slave: in_* request, out_* result), stop, lut_addr/lut_sys -> lut_angle.
// Optional: CORDIC_HYP_REPEAT_EN repeats hyperbolic shifts 4 and 13.
module cordic_seq_engine #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  cordic_seq_engine_if.slave job,
  input  logic              stop,
  output logic [ITER_W-1:0] lut_addr,
  output logic [1:0]        lut_sys,
  input  logic [WIDTH-1:0]  lut_angle
);
  localparam int M = WIDTH - 1;
  localparam logic [1:0] SYS_HYP = 2'b00;
  localparam logic [1:0] SYS_CIR = 2'b01;
  localparam logic [1:0] SYS_LIN = 2'b10;
  localparam logic [1:0] SYS_ERR = 2'b11;
  localparam logic [ITER_W-1:0] SH_MAX = '1;
  localparam logic [WIDTH:0] QUARTER = {3'b001, {(WIDTH-2){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE, S_PRE, S_ITER, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [1:0] sys_q, sys_d;
  logic mode_q, mode_d, ostop_q, ostop_d;
  logic [ITER_W-1:0] req_q, req_d;
  logic [ITER_W-1:0] shift_q, shift_d, cnt_q, cnt_d;
  logic [4:0] st_q, st_d;

  logic signed [WIDTH-1:0] xsh, ysh;
  logic d_pos, x_sub, x_ovf, y_ovf, z_ovf, rep_c;
  logic [WIDTH:0] x_sum, y_sum, z_sum, y_abs, z_abs;
  logic hyp_err, pre_flip;

  assign xsh = x_q >>> shift_q;
  assign ysh = y_q >>> shift_q;
  assign d_pos = mode_q ? !z_q[M] : y_q[M];
  // circular subtracts m*d*y; hyperbolic (m=-1) inverts the sense
  assign x_sub = (sys_q == SYS_CIR) ? d_pos : !d_pos;

  assign x_sum = x_sub ? {x_q[M], x_q} - {ysh[M], ysh}
                       : {x_q[M], x_q} + {ysh[M], ysh};
  assign y_sum = d_pos ? {y_q[M], y_q} + {xsh[M], xsh}
                       : {y_q[M], y_q} - {xsh[M], xsh};
  assign z_sum = d_pos ? {z_q[M], z_q} - {lut_angle[M], lut_angle}
                       : {z_q[M], z_q} + {lut_angle[M], lut_angle};

  assign x_ovf = (sys_q != SYS_LIN) && (x_sum[WIDTH] ^ x_sum[M]);
  assign y_ovf = y_sum[WIDTH] ^ y_sum[M];
  assign z_ovf = z_sum[WIDTH] ^ z_sum[M];

  // magnitudes one bit wider so the most negative value is exact
  assign y_abs = y_q[M] ? ({(WIDTH+1){1'b0}} - {1'b1, y_q})
                        : {1'b0, y_q};
  assign z_abs = z_q[M] ? ({(WIDTH+1){1'b0}} - {1'b1, z_q})
                        : {1'b0, z_q};
  assign hyp_err = x_q[M] || (y_abs >= {1'b0, x_q});
  assign pre_flip = mode_q ? (z_abs > QUARTER) : x_q[M];

`ifdef CORDIC_HYP_REPEAT_EN
  logic rep_q, rep_d;
  assign rep_c = (sys_q == SYS_HYP) && !rep_q &&
                 (shift_q == ITER_W'(4) || shift_q == ITER_W'(13));
  assign rep_d = (state_q == S_ITER) && rep_c;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rep_q <= 1'b0;
    else      rep_q <= rep_d;
  end
`else
  assign rep_c = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    sys_d = sys_q;
    mode_d = mode_q;
    ostop_d = ostop_q;
    req_d = req_q;
    shift_d = shift_q;
    cnt_d = cnt_q;
    st_d = st_q;
    unique case (state_q)
      S_IDLE: begin
        if (job.in_valid) begin
          x_d = job.in_x;
          y_d = job.in_y;
          z_d = job.in_z;
          sys_d = job.in_sys;
          mode_d = job.in_mode;
          ostop_d = job.in_ovf_stop;
          req_d = job.in_iters;
          shift_d = '0;
          cnt_d = '0;
          st_d = '0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        shift_d = (sys_q == SYS_HYP) ? ITER_W'(1) : '0;
        unique case (1'b1)
          sys_q == SYS_ERR,
          (sys_q == SYS_HYP) && hyp_err: begin
            st_d[0] = 1'b1;
            state_d = S_DONE;
          end
          default: begin
            // fold circular inputs into the convergence range
            if (sys_q == SYS_CIR && pre_flip) begin
              x_d = -x_q;
              y_d = -y_q;
              z_d = {~z_q[M], z_q[M-1:0]};
            end
            state_d = (req_q == '0) ? S_DONE : S_ITER;
          end
        endcase
      end
      S_ITER: begin
        x_d = (sys_q == SYS_LIN) ? x_q : x_sum[M:0];
        y_d = y_sum[M:0];
        z_d = z_sum[M:0];
        st_d[1] = st_q[1] | x_ovf;
        st_d[2] = st_q[2] | y_ovf;
        st_d[3] = st_q[3] | z_ovf;
        if (!rep_c) begin
          cnt_d = cnt_q + ITER_W'(1);
          if (shift_q != SH_MAX) shift_d = shift_q + ITER_W'(1);
        end
        if (stop) st_d[4] = 1'b1;
        if (stop || (ostop_q && |st_d[3:1]) ||
            (!rep_c && (cnt_q + ITER_W'(1) == req_q)) ||
            (!rep_c && shift_q == SH_MAX))
          state_d = S_DONE;
      end
      S_DONE: begin
        if (job.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      sys_q <= '0;
      mode_q <= 1'b0;
      ostop_q <= 1'b0;
      req_q <= '0;
      shift_q <= '0;
      cnt_q <= '0;
      st_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      sys_q <= sys_d;
      mode_q <= mode_d;
      ostop_q <= ostop_d;
      req_q <= req_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      st_q <= st_d;
    end
  end

  assign job.in_ready = (state_q == S_IDLE);
  assign job.out_valid = (state_q == S_DONE);
  assign job.out_x = x_q;
  assign job.out_y = y_q;
  assign job.out_z = z_q;
  assign job.out_iters = cnt_q;
  assign job.out_status = st_q;
  assign lut_addr = shift_q;
  assign lut_sys = sys_q;
endmodule

// File: tb/tb_cordic_seq_engine.sv
// Scoreboard bench for cordic_seq_engine: driver issues directed jobs and
// queues expectations, monitor pops and checks each result.
module tb_cordic_seq_engine;
  localparam int W = 32;
  localparam int IW = 5;
`ifdef CORDIC_HYP_REPEAT_EN
  localparam int HYP_LAT = 20;
`else
  localparam int HYP_LAT = 18;
`endif
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stop = 1'b0;
  logic [IW-1:0] lut_addr;
  logic [1:0] lut_sys;
  logic [W-1:0] lut_angle;
  logic [W-1:0] tab [0:127];

  always #5 clk = ~clk;

  cordic_seq_engine_if #(.WIDTH(W), .ITER_W(IW)) bus ();

  cordic_seq_engine #(.WIDTH(W), .ITER_W(IW)) dut (
    .clk(clk),
    .rst(rst),
    .job(bus),
    .stop(stop),
    .lut_addr(lut_addr),
    .lut_sys(lut_sys),
    .lut_angle(lut_angle)
  );

  assign lut_angle = tab[{lut_sys, lut_addr}];

  typedef struct {
    int id;
    logic [31:0] x, y, z;
    int tol;
    logic [4:0] st;
    logic [4:0] it;
    int lat;
    int hold;
    time tacc;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int n_chk = 0;
  int n_fail = 0;
  int n_issued = 0;
  int n_done = 0;

  function automatic void chk(input int id, input string nm,
                              input longint act, input longint ex,
                              input longint tol);
    n_chk++;
    if (act - ex > tol || ex - act > tol) begin
      n_fail++;
      $display("FAIL job%0d %s: got %0d required %0d (tol %0d)",
               id, nm, act, ex, tol);
    end
  endfunction

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(0.5 - r);
  endfunction

  // real-valued circular rotation reference using the bench's own LUT
  function automatic void circ_ref(input logic [31:0] x0, y0, z0,
                                   input int n,
                                   output logic [31:0] xo, yo, zo);
    real x, y, xn, t;
    logic [31:0] z;
    logic [32:0] za;
    x = $itor($signed(x0));
    y = $itor($signed(y0));
    z = z0;
    za = z[31] ? (33'd0 - {1'b1, z}) : {1'b0, z};
    if (za > 33'h040000000) begin
      x = -x;
      y = -y;
      z[31] = ~z[31];
    end
    t = 1.0;
    for (int i = 0; i < n; i++) begin
      if (!z[31]) begin
        xn = x - y * t;
        y = y + x * t;
        z = z - tab[32 + i];
      end else begin
        xn = x + y * t;
        y = y - x * t;
        z = z + tab[32 + i];
      end
      x = xn;
      t = t / 2.0;
    end
    xo = rnd(x);
    yo = rnd(y);
    zo = z;
  endfunction

  task automatic issue(input int id, input logic [1:0] sys,
                       input logic mode, input logic [31:0] x, y, z,
                       input logic [4:0] it, input logic ostp,
                       input int stop_at, input exp_t e);
    int k;
    bus.in_x = x;
    bus.in_y = y;
    bus.in_z = z;
    bus.in_sys = sys;
    bus.in_mode = mode;
    bus.in_iters = it;
    bus.in_ovf_stop = ostp;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      chk(id, "accept_timeout", 0, 1, 0);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.id = id;
    e.tacc = $time;
    if (e.lat >= 0) begin
      sb.push_back(e);
      n_issued++;
    end
    #1 bus.in_valid = 1'b0;
    if (stop_at > 0) begin
      repeat (stop_at) @(posedge clk);
      #1 stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
    end
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (n_done < n_issued && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (n_done < n_issued) chk(0, "result_timeout", n_done, n_issued, 0);
  endtask

  // monitor
  initial begin
    logic [31:0] sx, sy, sz;
    int lat;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && bus.out_valid) begin
        if (sb.size() == 0) begin
          chk(-1, "unexpected_result", 1, 0, 0);
        end else begin
          m_e = sb.pop_front();
          lat = int'(($time - m_e.tacc + 5) / 10);
          if (m_e.tol >= 0) begin
            chk(m_e.id, "x", $signed(bus.out_x), $signed(m_e.x), m_e.tol);
            chk(m_e.id, "y", $signed(bus.out_y), $signed(m_e.y), m_e.tol);
            chk(m_e.id, "z", $signed(bus.out_z), $signed(m_e.z), m_e.tol);
          end
          chk(m_e.id, "status", bus.out_status, m_e.st, 0);
          chk(m_e.id, "iters", bus.out_iters, m_e.it, 0);
          chk(m_e.id, "latency", lat, m_e.lat, 0);
          sx = bus.out_x;
          sy = bus.out_y;
          sz = bus.out_z;
          for (int h = 0; h < m_e.hold; h++) begin
            @(negedge clk);
            chk(m_e.id, "hold_valid", bus.out_valid, 1, 0);
            chk(m_e.id, "hold_in_ready", bus.in_ready, 0, 0);
            chk(m_e.id, "hold_xyz", {bus.out_x ^ sx, bus.out_y ^ sy}
                | {32'd0, bus.out_z ^ sz}, 0, 0);
          end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        n_done++;
      end
    end
  end

  // driver
  initial begin
    exp_t e;
    real t;
    logic [31:0] rx, ry, rz;
    for (int i = 0; i < 32; i++) begin
      t = 1.0;
      for (int j = 0; j < i; j++) t = t / 2.0;
      tab[i] = (i == 0) ? 32'd0 :
               rnd(0.5 * $ln((1.0 + t) / (1.0 - t)) * 2147483648.0 / PI);
      tab[32 + i] = rnd($atan(t) * 2147483648.0 / PI);
      tab[64 + i] = 32'h4000_0000 >> i;
      tab[96 + i] = 32'd0;
    end
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_y = '0;
    bus.in_z = '0;
    bus.in_sys = '0;
    bus.in_mode = 1'b0;
    bus.in_iters = '0;
    bus.in_ovf_stop = 1'b0;
    repeat (2) @(negedge clk);
    chk(0, "rst_in_ready", bus.in_ready, 1, 0);
    chk(0, "rst_out_valid", bus.out_valid, 0, 0);
    chk(0, "rst_out_x", bus.out_x, 0, 0);
    chk(0, "rst_out_iters", bus.out_iters, 0, 0);
    chk(0, "rst_status", bus.out_status, 0, 0);
    chk(0, "rst_lut_addr", lut_addr, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: circular rotation by pi/4 of the gain-compensated unit vector
    circ_ref(32'h26DD3B6A, 0, 32'h20000000, 24, rx, ry, rz);
    e = '{0, rx, ry, rz, 40, 5'd0, 5'd24, 26, 0, 0};
    issue(1, 2'b01, 1'b1, 32'h26DD3B6A, 0, 32'h20000000, 5'd24, 0, 0, e);
    // 2: hyperbolic out of range -> input error, operands untouched
    e = '{0, 32'd1, 32'd2, 32'h1234, 0, 5'b00001, 5'd0, 2, 0, 0};
    issue(2, 2'b00, 1'b1, 32'd1, 32'd2, 32'h1234, 5'd8, 0, 0, e);
    // 3: stop during 5th iteration
    e = '{0, 0, 0, 0, -1, 5'b10000, 5'd5, 7, 0, 0};
    issue(3, 2'b01, 1'b1, 32'h10000000, 0, 32'h08000000, 5'd31, 0, 5, e);
    // 4: vectoring x overflow on first iteration, ovf_stop
    e = '{0, 32'hFFFFFFE0, 32'd0, 32'h20000000, 0, 5'b00010, 5'd1, 3, 0, 0};
    issue(4, 2'b01, 1'b0, 32'h7FFFFFF0, 32'h7FFFFFF0, 0, 5'd8, 1, 0, e);
    // 5: linear multiply 1.0*0.5, result held 10 cycles
    e = '{0, 32'h40000000, 32'h20000000, 0, 0, 5'd0, 5'd2, 4, 10, 0};
    issue(5, 2'b10, 1'b1, 32'h40000000, 0, 32'h20000000, 5'd2, 0, 0, e);
    // 6: zero iterations
    e = '{0, 32'h100, 32'h200, 32'h300, 0, 5'd0, 5'd0, 2, 0, 0};
    issue(6, 2'b01, 1'b1, 32'h100, 32'h200, 32'h300, 5'd0, 0, 0, e);
    // 7: illegal system
    e = '{0, 32'd5, 32'd6, 32'd7, 0, 5'b00001, 5'd0, 2, 0, 0};
    issue(7, 2'b11, 1'b1, 32'd5, 32'd6, 32'd7, 5'd4, 0, 0, e);
    // 8: circular rotation by 3pi/4 needs the pre-rotation fold
    circ_ref(32'h26DD3B6A, 0, 32'h60000000, 24, rx, ry, rz);
    e = '{0, rx, ry, rz, 40, 5'd0, 5'd24, 26, 0, 0};
    issue(8, 2'b01, 1'b1, 32'h26DD3B6A, 0, 32'h60000000, 5'd24, 0, 0, e);
    // 9: hyperbolic 16 logical iterations
    e = '{0, 0, 0, 0, -1, 5'd0, 5'd16, HYP_LAT, 0, 0};
    issue(9, 2'b00, 1'b1, 32'h40000000, 0, 32'h08000000, 5'd16, 0, 0, e);
    wait_done(2000);

    // 10: reset in the middle of a hyperbolic job
    e = '{0, 0, 0, 0, -1, 5'd0, 5'd0, -1, 0, 0};
    issue(10, 2'b00, 1'b1, 32'h40000000, 0, 32'h08000000, 5'd16, 0, 0, e);
    repeat (4) @(posedge clk);
    #1;
    chk(10, "busy_in_ready", bus.in_ready, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk(10, "mid_rst_in_ready", bus.in_ready, 1, 0);
    chk(10, "mid_rst_out_valid", bus.out_valid, 0, 0);
    chk(10, "mid_rst_xyz", {bus.out_x, bus.out_y} | {32'd0, bus.out_z}, 0, 0);
    chk(10, "mid_rst_iters", bus.out_iters, 0, 0);
    chk(10, "mid_rst_status", bus.out_status, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (30) @(negedge clk);
    chk(10, "no_result_after_rst", bus.out_valid, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
